// File: rtl/hvac_pkg.sv
// ============================================================================
// Module   : hvac_pkg
// Brief    : Shared types and default timing for the HVAC plant arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hvac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Bit order matches the zone ac controller: heating = bit1, cooling = bit0.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_COOL = 2'b01,
        MODE_HEAT = 2'b10
    } mode_e;

    localparam int DEF_N_ZONES = 4;
    localparam int DEF_MIN_RUN = 8;
    localparam int DEF_MAX_RUN = 32;
    localparam int DEF_MIN_OFF = 4;

    function automatic logic [1:0] mode_of(input logic heat, input logic cool);
        return {heat & ~cool, cool & ~heat};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotating-priority finder starting at ptr_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    int j;

    // Scan from the farthest offset down so the nearest eligible zone wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (eligible_i[j]) begin
                found_o = 1'b1;
                idx_o   = PW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hvac_zone_arbiter.sv
// ============================================================================
// Module   : hvac_zone_arbiter
// Brief    : Round-robin sharing of one heat/cool plant with run/guard timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hvac_zone_arbiter
    import hvac_pkg::*;
#(
    parameter int N_ZONES = DEF_N_ZONES,
    parameter int MIN_RUN = DEF_MIN_RUN,
    parameter int MAX_RUN = DEF_MAX_RUN,
    parameter int MIN_OFF = DEF_MIN_OFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic [N_ZONES-1:0] grant,
    output logic               heating,
    output logic               cooling,
    output logic               busy
);

    localparam int PTR_W = $clog2(N_ZONES);
    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam int GRD_W = $clog2(MIN_OFF + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_GUARD = GUARD;

    logic [1:0]         state_q,     state_d;
    logic [N_ZONES-1:0] grant_q,     grant_d;
    logic [1:0]         mode_q,      mode_d;
    logic [RUN_W-1:0]   run_cnt_q,   run_cnt_d;
    logic [GRD_W-1:0]   guard_cnt_q, guard_cnt_d;
    logic [PTR_W-1:0]   ptr_q,       ptr_d;

    logic [N_ZONES-1:0] eligible;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic               held;
    logic               release_run;

    assign eligible = heat_req ^ cool_req;

    rr_pick #(
        .N  (N_ZONES),
        .PW (PTR_W)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    // A zone flipping to the other mode or to both modes no longer holds.
    assign held = mode_q[1] ? |(grant_q & heat_req & ~cool_req)
                            : |(grant_q & cool_req & ~heat_req);

    assign release_run = ((run_cnt_q >= RUN_W'(MIN_RUN)) && !held) ||
                         (run_cnt_q == RUN_W'(MAX_RUN));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mode_d      = mode_q;
        run_cnt_d   = run_cnt_q;
        guard_cnt_d = guard_cnt_q;
        ptr_d       = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d   = ST_RUN;
                    grant_d   = N_ZONES'(1) << pick_idx;
                    mode_d    = mode_of(heat_req[pick_idx], cool_req[pick_idx]);
                    run_cnt_d = RUN_W'(1);
                    ptr_d     = (pick_idx == PTR_W'(N_ZONES - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_RUN: begin
                if (release_run) begin
                    state_d     = ST_GUARD;
                    grant_d     = '0;
                    mode_d      = MODE_OFF;
                    guard_cnt_d = GRD_W'(1);
                end else if (run_cnt_q != RUN_W'(MAX_RUN)) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == GRD_W'(MIN_OFF)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                mode_d  = MODE_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            mode_q      <= MODE_OFF;
            run_cnt_q   <= '0;
            guard_cnt_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mode_q      <= mode_d;
            run_cnt_q   <= run_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant   = grant_q;
    assign heating = mode_q[1];
    assign cooling = mode_q[0];
    assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire
